// File: rtl/path_egress_pkg.sv
// Shared constants and types for the per-path egress buffer.
// The optional drop-counter feature is selected with PATH_EGRESS_DROP_CNT_EN.
package path_egress_pkg;

  localparam int PATH_COUNT_DEF = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int DEPTH_DEF      = 4;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int PTR_WIDTH_DEF  = $clog2(DEPTH_DEF);

  // One data word as delivered by the router
  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  // Read/write pointer: wraps naturally because DEPTH is a power of two
  typedef logic [PTR_WIDTH_DEF-1:0]  ptr_t;
  // Occupancy: one extra bit so that DEPTH itself is representable
  typedef logic [PTR_WIDTH_DEF:0]    count_t;

endpackage

// File: rtl/path_egress_fifo.sv
// Single-path FIFO for the egress buffer. Accepts a push while full only if
// the head is popped in the same cycle; otherwise flags the word as dropped.
module path_egress_fifo
  import path_egress_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_rdy,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;

  logic                  w_vld;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [CW-1:0]         w_count_nxt;

  // Decide pop/accept/drop for this cycle and the next occupancy
  always_comb begin
    w_vld       = (r_count != {CW{1'b0}});
    w_pop       = w_vld & i_rdy;
    w_push_ok   = i_push & (~r_full | w_pop);
    o_drop      = i_push & r_full & ~w_pop;
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointer, occupancy and full-flag state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Storage; reset to zero so the head word is never X
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/path_egress_buffer.sv
// Per-path egress buffer downstream of the packet router: steers the shared
// data bus into one FIFO per path and counts words dropped at full paths.
// Optional feature macro: PATH_EGRESS_DROP_CNT_EN (drop counters + iDropClr).
module path_egress_buffer
  import path_egress_pkg::*;
#(
  parameter int PATH_COUNT = PATH_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic [DATA_WIDTH-1:0]                 iData,
  input  logic [PATH_COUNT-1:0]                 iDataVld,
  output logic [PATH_COUNT-1:0][DATA_WIDTH-1:0] oPathData,
  output logic [PATH_COUNT-1:0]                 oPathVld,
  input  logic [PATH_COUNT-1:0]                 iPathRdy,
  output logic [PATH_COUNT-1:0]                 oPathFull,
  input  logic                                  iDropClr,
  output logic [PATH_COUNT-1:0][CNT_WIDTH-1:0]  oDropCnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PATH_COUNT-1:0][CW-1:0] w_count;
  logic [PATH_COUNT-1:0]         w_drop;

  for (genvar p = 0; p < PATH_COUNT; p++) begin : g_path
    path_egress_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .i_clk   (iClk),
      .i_rst   (iRst),
      .i_push  (iDataVld[p]),
      .i_data  (iData),
      .i_rdy   (iPathRdy[p]),
      .o_data  (oPathData[p]),
      .o_full  (oPathFull[p]),
      .o_count (w_count[p]),
      .o_drop  (w_drop[p])
    );
    assign oPathVld[p] = (w_count[p] != {CW{1'b0}});
  end

`ifdef PATH_EGRESS_DROP_CNT_EN
  logic [PATH_COUNT-1:0][CNT_WIDTH-1:0] r_drop_cnt;

  // Saturating per-path drop counters; a clear beats a coincident drop
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_drop_cnt <= {(PATH_COUNT*CNT_WIDTH){1'b0}};
    end else if (iDropClr) begin
      r_drop_cnt <= {(PATH_COUNT*CNT_WIDTH){1'b0}};
    end else begin
      for (int p = 0; p < PATH_COUNT; p++) begin
        if (w_drop[p] && (r_drop_cnt[p] != {CNT_WIDTH{1'b1}})) begin
          r_drop_cnt[p] <= r_drop_cnt[p] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign oDropCnt = r_drop_cnt;
`else
  logic w_unused;

  // Without counters the drop flags and clear have no consumer
  assign w_unused = &{1'b0, w_drop, iDropClr};
  assign oDropCnt = {(PATH_COUNT*CNT_WIDTH){1'b0}};
`endif

endmodule
